// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - in-order load/store queue with CDB snooping, store commit and flush
module load_store_buffer #(
    parameter int LSB_SIZE     = 8,
    parameter int ROB_ID_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    dec2lsb_en,
    input  logic                    dec_is_store,
    input  logic [2:0]              dec_funct3,
    input  logic [31:0]             dec_imm,
    input  logic [ROB_ID_WIDTH:0]   dec_tag,
    input  logic [ROB_ID_WIDTH:0]   label1,
    input  logic [ROB_ID_WIDTH:0]   label2,
    input  logic [31:0]             res1,
    input  logic [31:0]             res2,
    input  logic                    ready1,
    input  logic                    ready2,
    input  logic                    rs_cdb_en,
    input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
    input  logic [31:0]             rs_cdb2val,
    input  logic                    rob2lsb_store_en,
    input  logic [ROB_ID_WIDTH:0]   store_index,
    output logic                    lsb2mem_en,
    output logic                    lsb2mem_wr,
    output logic [31:0]             lsb2mem_addr,
    output logic [31:0]             lsb2mem_wdata,
    output logic [1:0]              lsb2mem_len,
    input  logic                    mem_done,
    input  logic [31:0]             mem_rdata,
    output logic                    lsb_cdb_en,
    output logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
    output logic [31:0]             lsb_cdb2val,
    output logic                    lsbFull
);
    localparam int LW = ROB_ID_WIDTH + 1;
    localparam int PW = (LSB_SIZE > 1) ? $clog2(LSB_SIZE) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_n;

    logic [LSB_SIZE-1:0] busy, is_store, committed, announced;
    logic [2:0]          funct3 [LSB_SIZE];
    logic [31:0]         imm    [LSB_SIZE];
    logic [31:0]         v1     [LSB_SIZE];
    logic [31:0]         v2     [LSB_SIZE];
    logic [LW-1:0]       tag    [LSB_SIZE];
    logic [LW-1:0]       q1     [LSB_SIZE];
    logic [LW-1:0]       q2     [LSB_SIZE];
    logic [PW-1:0]       head, tail;
    logic [CW-1:0]       count, commit_cnt, cc_next;
    // set when a flush orphans the in-flight load: its completion neither pops nor broadcasts
    logic                kill;

    logic          head_ready, issue, pop, accept;
    logic          ann_found, commit_hit;
    logic [PW-1:0] ann_idx, commit_idx, scan_idx;
    logic [LW-1:0] cap_q1, cap_q2;
    logic [31:0]   cap_v1, cap_v2, load_ext;

    assign lsbFull    = (count == CW'(LSB_SIZE));
    assign head_ready = busy[head] && (q1[head] == '0) &&
                        (!is_store[head] || ((q2[head] == '0) && committed[head]));
    assign issue      = (state == IDLE) && head_ready && !flush_in;
    assign pop        = (state == REQ) && mem_done && !kill;
    // a pop frees the head slot in the same cycle, so a full queue can still accept
    assign accept     = dec2lsb_en && (!lsbFull || pop) && !flush_in;
    assign cc_next    = commit_cnt + CW'(commit_hit) - CW'(pop && is_store[head]);

    // operand capture at dispatch, including same-cycle forwarding from either CDB
    always_comb begin
        cap_q1 = label1;
        cap_v1 = 32'h0;
        if (ready1 || label1 == '0) begin
            cap_q1 = '0; cap_v1 = res1;
        end else if (rs_cdb_en && rs_cdb2lab == label1) begin
            cap_q1 = '0; cap_v1 = rs_cdb2val;
        end else if (lsb_cdb_en && lsb_cdb2lab == label1) begin
            cap_q1 = '0; cap_v1 = lsb_cdb2val;
        end
        cap_q2 = label2;
        cap_v2 = 32'h0;
        if (ready2 || label2 == '0) begin
            cap_q2 = '0; cap_v2 = res2;
        end else if (rs_cdb_en && rs_cdb2lab == label2) begin
            cap_q2 = '0; cap_v2 = rs_cdb2val;
        end else if (lsb_cdb_en && lsb_cdb2lab == label2) begin
            cap_q2 = '0; cap_v2 = lsb_cdb2val;
        end
    end

    // oldest store with resolved operands that has not yet told the ROB it is ready
    always_comb begin
        ann_found = 1'b0;
        ann_idx   = head;
        scan_idx  = head;
        for (int i = 0; i < LSB_SIZE; i++) begin
            scan_idx = head + PW'(i);
            if (!ann_found && busy[scan_idx] && is_store[scan_idx] && !announced[scan_idx] &&
                q1[scan_idx] == '0 && q2[scan_idx] == '0) begin
                ann_found = 1'b1;
                ann_idx   = scan_idx;
            end
        end
    end

    // locate the store the ROB is committing
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int i = 0; i < LSB_SIZE; i++) begin
            if (rob2lsb_store_en && busy[PW'(i)] && is_store[PW'(i)] && !committed[PW'(i)] &&
                tag[PW'(i)] == store_index) begin
                commit_hit = 1'b1;
                commit_idx = PW'(i);
            end
        end
    end

    // width and sign handling of the low-aligned read data
    always_comb begin
        case (funct3[head])
            3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_ext = {24'h0, mem_rdata[7:0]};
            3'b101:  load_ext = {16'h0, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst_in) state <= IDLE;
        else        state <= state_n;
    end

    // next state: issue from the head, return on a sampled completion
    always_comb begin
        state_n = state;
        if (rdy_in) begin
            case (state)
                IDLE:    if (issue)    state_n = REQ;
                REQ:     if (mem_done) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // queue storage, pointers, memory request and LSB CDB registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            busy <= '0; is_store <= '0; committed <= '0; announced <= '0;
            for (int i = 0; i < LSB_SIZE; i++) begin
                funct3[PW'(i)] <= '0; imm[PW'(i)] <= '0; tag[PW'(i)] <= '0;
                q1[PW'(i)] <= '0; v1[PW'(i)] <= '0; q2[PW'(i)] <= '0; v2[PW'(i)] <= '0;
            end
            head <= '0; tail <= '0; count <= '0; commit_cnt <= '0; kill <= 1'b0;
            lsb2mem_en <= 1'b0; lsb2mem_wr <= 1'b0; lsb2mem_addr <= '0;
            lsb2mem_wdata <= '0; lsb2mem_len <= '0;
            lsb_cdb_en <= 1'b0; lsb_cdb2lab <= '0; lsb_cdb2val <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (busy[PW'(i)]) begin
                    if (rs_cdb_en && q1[PW'(i)] != '0 && q1[PW'(i)] == rs_cdb2lab) begin
                        q1[PW'(i)] <= '0; v1[PW'(i)] <= rs_cdb2val;
                    end else if (lsb_cdb_en && q1[PW'(i)] != '0 && q1[PW'(i)] == lsb_cdb2lab) begin
                        q1[PW'(i)] <= '0; v1[PW'(i)] <= lsb_cdb2val;
                    end
                    if (rs_cdb_en && q2[PW'(i)] != '0 && q2[PW'(i)] == rs_cdb2lab) begin
                        q2[PW'(i)] <= '0; v2[PW'(i)] <= rs_cdb2val;
                    end else if (lsb_cdb_en && q2[PW'(i)] != '0 && q2[PW'(i)] == lsb_cdb2lab) begin
                        q2[PW'(i)] <= '0; v2[PW'(i)] <= lsb_cdb2val;
                    end
                end
            end
            if (commit_hit) committed[commit_idx] <= 1'b1;

            lsb_cdb_en <= 1'b0;
            if (!flush_in) begin
                if (pop && !is_store[head]) begin
                    lsb_cdb_en <= 1'b1; lsb_cdb2lab <= tag[head]; lsb_cdb2val <= load_ext;
                end else if (ann_found) begin
                    lsb_cdb_en <= 1'b1; lsb_cdb2lab <= tag[ann_idx]; lsb_cdb2val <= 32'h0;
                    announced[ann_idx] <= 1'b1;
                end
            end

            if (issue) begin
                lsb2mem_en    <= 1'b1;
                lsb2mem_wr    <= is_store[head];
                lsb2mem_addr  <= v1[head] + imm[head];
                lsb2mem_wdata <= v2[head];
                lsb2mem_len   <= funct3[head][1:0];
            end else if (state == REQ && mem_done) begin
                lsb2mem_en <= 1'b0;
            end
            if (state == REQ && mem_done)                         kill <= 1'b0;
            else if (flush_in && state == REQ && !is_store[head]) kill <= 1'b1;

            if (pop) begin
                busy[head] <= 1'b0; committed[head] <= 1'b0;
            end
            if (flush_in) begin
                for (int i = 0; i < LSB_SIZE; i++)
                    if (!(committed[PW'(i)] || (commit_hit && commit_idx == PW'(i))))
                        busy[PW'(i)] <= 1'b0;
            end
            if (accept) begin
                busy[tail] <= 1'b1; is_store[tail] <= dec_is_store;
                funct3[tail] <= dec_funct3; imm[tail] <= dec_imm; tag[tail] <= dec_tag;
                q1[tail] <= cap_q1; v1[tail] <= cap_v1; q2[tail] <= cap_q2; v2[tail] <= cap_v2;
                committed[tail] <= 1'b0; announced[tail] <= 1'b0;
            end

            head       <= head + PW'(pop);
            commit_cnt <= cc_next;
            if (flush_in) begin
                tail  <= head + PW'(pop) + cc_next[PW-1:0];
                count <= cc_next;
            end else begin
                tail  <= tail + PW'(accept);
                count <= count + CW'(accept) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_load_store_buffer.sv
// tb/tb_load_store_buffer.sv - scoreboard bench for load_store_buffer
module tb_load_store_buffer;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        dec2lsb_en, dec_is_store;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm, res1, res2, rs_cdb2val, mem_rdata;
    logic [3:0]  dec_tag, label1, label2, rs_cdb2lab, store_index;
    logic        ready1, ready2, rs_cdb_en, rob2lsb_store_en, mem_done;
    logic        lsb2mem_en, lsb2mem_wr, lsb_cdb_en, lsbFull;
    logic [31:0] lsb2mem_addr, lsb2mem_wdata, lsb_cdb2val;
    logic [1:0]  lsb2mem_len;
    logic [3:0]  lsb_cdb2lab;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; logic [1:0] len; } mem_exp_t;
    typedef struct { logic [3:0] lab; logic [31:0] val; } cdb_exp_t;
    mem_exp_t mem_q[$];
    cdb_exp_t cdb_q[$];
    int errors = 0;
    int checks = 0;
    logic prev_en = 1'b0;

    load_store_buffer #(.LSB_SIZE(8), .ROB_ID_WIDTH(3)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dec2lsb_en(dec2lsb_en), .dec_is_store(dec_is_store), .dec_funct3(dec_funct3),
        .dec_imm(dec_imm), .dec_tag(dec_tag), .label1(label1), .label2(label2),
        .res1(res1), .res2(res2), .ready1(ready1), .ready2(ready2),
        .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
        .rob2lsb_store_en(rob2lsb_store_en), .store_index(store_index),
        .lsb2mem_en(lsb2mem_en), .lsb2mem_wr(lsb2mem_wr), .lsb2mem_addr(lsb2mem_addr),
        .lsb2mem_wdata(lsb2mem_wdata), .lsb2mem_len(lsb2mem_len),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab), .lsb_cdb2val(lsb_cdb2val),
        .lsbFull(lsbFull)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: every broadcast and every new memory request is matched against the queues
    always @(posedge clk) begin
        #1;
        if (!rst_in) begin
            if (lsb_cdb_en) begin
                if (cdb_q.size() == 0) begin
                    check("cdb_unexpected", {28'h0, lsb_cdb2lab}, 32'hFFFF_FFFF);
                end else begin
                    cdb_exp_t e;
                    e = cdb_q.pop_front();
                    check("cdb_lab", {28'h0, lsb_cdb2lab}, {28'h0, e.lab});
                    check("cdb_val", lsb_cdb2val, e.val);
                end
            end
            if (lsb2mem_en && !prev_en) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", lsb2mem_addr, 32'hFFFF_FFFF);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_wr", {31'h0, lsb2mem_wr}, {31'h0, m.wr});
                    check("mem_addr", lsb2mem_addr, m.addr);
                    check("mem_wdata", lsb2mem_wdata, m.wdata);
                    check("mem_len", {30'h0, lsb2mem_len}, {30'h0, m.len});
                end
            end
            prev_en = lsb2mem_en;
        end
    end

    task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] len);
        mem_exp_t m;
        m.wr = wr; m.addr = addr; m.wdata = wdata; m.len = len;
        mem_q.push_back(m);
    endtask

    task automatic push_cdb(input logic [3:0] lab, input logic [31:0] val);
        cdb_exp_t c;
        c.lab = lab; c.val = val;
        cdb_q.push_back(c);
    endtask

    task automatic dispatch(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                            input logic [3:0] tg, input logic [3:0] l1, input logic [31:0] r1,
                            input logic rd1, input logic [3:0] l2, input logic [31:0] r2,
                            input logic rd2);
        @(negedge clk);
        dec2lsb_en = 1'b1; dec_is_store = st; dec_funct3 = f3; dec_imm = imm; dec_tag = tg;
        label1 = l1; res1 = r1; ready1 = rd1; label2 = l2; res2 = r2; ready2 = rd2;
        @(negedge clk);
        dec2lsb_en = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                        input logic [3:0] tg);
        dispatch(1'b0, f3, imm, tg, 4'd0, base, 1'b1, 4'd0, 32'h0, 1'b1);
    endtask

    task automatic wait_req(output logic ok);
        ok = lsb2mem_en;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = lsb2mem_en;
        end
        if (!ok) check("req_timeout", 32'h0, 32'h1);
    endtask

    task automatic serve(input logic [31:0] rdata, input logic is_load);
        logic ok;
        @(negedge clk);
        wait_req(ok);
        if (ok) begin
            mem_done = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            if (is_load) check("cdb_latency", {31'h0, lsb_cdb_en}, 32'h1);
            mem_done = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; dec2lsb_en = 1'b0; dec_is_store = 1'b0;
        dec_funct3 = 3'd0; dec_imm = 32'h0; dec_tag = 4'd0; label1 = 4'd0; label2 = 4'd0;
        res1 = 32'h0; res2 = 32'h0; ready1 = 1'b0; ready2 = 1'b0;
        rs_cdb_en = 1'b0; rs_cdb2lab = 4'd0; rs_cdb2val = 32'h0;
        rob2lsb_store_en = 1'b0; store_index = 4'd0; mem_done = 1'b0; mem_rdata = 32'h0;
        idle(3);
        check("rst_mem_en", {31'h0, lsb2mem_en}, 32'h0);
        check("rst_cdb_en", {31'h0, lsb_cdb_en}, 32'h0);
        check("rst_full", {31'h0, lsbFull}, 32'h0);
        check("rst_addr", lsb2mem_addr, 32'h0);
        rst_in = 1'b0;

        // load word
        push_mem(1'b0, 32'h104, 32'h0, 2'd2);
        push_cdb(4'd2, 32'hDEADBEEF);
        load(3'b010, 32'h100, 32'h4, 4'd2);
        serve(32'hDEADBEEF, 1'b1);

        // byte / halfword extension
        push_mem(1'b0, 32'h200, 32'h0, 2'd0); push_cdb(4'd3, 32'hFFFFFF80);
        load(3'b000, 32'h200, 32'h0, 4'd3);
        serve(32'h00000080, 1'b1);
        push_mem(1'b0, 32'h301, 32'h0, 2'd0); push_cdb(4'd4, 32'h00000080);
        load(3'b100, 32'h300, 32'h1, 4'd4);
        serve(32'h00000080, 1'b1);
        push_mem(1'b0, 32'h402, 32'h0, 2'd1); push_cdb(4'd5, 32'hFFFF8000);
        load(3'b001, 32'h400, 32'h2, 4'd5);
        serve(32'h00018000, 1'b1);

        // store waits for data then commit
        dispatch(1'b1, 3'b010, 32'h8, 4'd6, 4'd0, 32'h400, 1'b1, 4'd3, 32'h0, 1'b0);
        idle(3);
        push_cdb(4'd6, 32'h0);
        @(negedge clk); rs_cdb_en = 1'b1; rs_cdb2lab = 4'd3; rs_cdb2val = 32'h55;
        @(negedge clk); rs_cdb_en = 1'b0;
        idle(5);
        check("store_precommit_idle", {31'h0, lsb2mem_en}, 32'h0);
        push_mem(1'b1, 32'h408, 32'h55, 2'd2);
        @(negedge clk); rob2lsb_store_en = 1'b1; store_index = 4'd6;
        @(negedge clk); rob2lsb_store_en = 1'b0;
        serve(32'h0, 1'b0);
        idle(2);

        // fill to full, ignored dispatch, dispatch plus pop while full
        for (int i = 0; i < 8; i++) begin
            push_mem(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 2'd2);
            push_cdb(4'(8 + i), 32'h100 + 32'(i));
        end
        push_mem(1'b0, 32'h2000, 32'h0, 2'd2);
        push_cdb(4'd2, 32'h2222);
        for (int i = 0; i < 8; i++) load(3'b010, 32'h1000, 32'(4 * i), 4'(8 + i));
        check("full_after_8", {31'h0, lsbFull}, 32'h1);
        load(3'b010, 32'h3000, 32'h0, 4'd1);
        check("full_after_ignored", {31'h0, lsbFull}, 32'h1);
        @(negedge clk);
        dec2lsb_en = 1'b1; dec_is_store = 1'b0; dec_funct3 = 3'b010; dec_imm = 32'h0;
        dec_tag = 4'd2; label1 = 4'd0; res1 = 32'h2000; ready1 = 1'b1;
        label2 = 4'd0; res2 = 32'h0; ready2 = 1'b1;
        mem_done = 1'b1; mem_rdata = 32'h100;
        @(negedge clk);
        dec2lsb_en = 1'b0; mem_done = 1'b0;
        check("pop_dispatch_cdb", {31'h0, lsb_cdb_en}, 32'h1);
        check("pop_dispatch_full", {31'h0, lsbFull}, 32'h1);
        for (int i = 1; i < 8; i++) serve(32'h100 + 32'(i), 1'b1);
        serve(32'h2222, 1'b1);
        idle(2);
        check("drained_not_full", {31'h0, lsbFull}, 32'h0);

        // flush with committed store in flight and younger loads
        push_cdb(4'd1, 32'h0);
        dispatch(1'b1, 3'b010, 32'h0, 4'd1, 4'd0, 32'h500, 1'b1, 4'd0, 32'hAA, 1'b1);
        load(3'b010, 32'h700, 32'h0, 4'd2);
        load(3'b010, 32'h704, 32'h0, 4'd3);
        load(3'b010, 32'h708, 32'h0, 4'd4);
        push_mem(1'b1, 32'h500, 32'hAA, 2'd2);
        @(negedge clk); rob2lsb_store_en = 1'b1; store_index = 4'd1;
        @(negedge clk); rob2lsb_store_en = 1'b0;
        wait_req(ok);
        flush_in = 1'b1;
        @(negedge clk); flush_in = 1'b0;
        serve(32'h0, 1'b0);
        idle(10);
        check("flush_count", 32'(dut.count), 32'h0);
        check("flush_mem_idle", {31'h0, lsb2mem_en}, 32'h0);

        // rdy_in low during an outstanding request
        push_mem(1'b0, 32'h600, 32'h0, 2'd2);
        push_cdb(4'd5, 32'h12345678);
        load(3'b010, 32'h600, 32'h0, 4'd5);
        wait_req(ok);
        rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_en", {31'h0, lsb2mem_en}, 32'h1);
            check("hold_addr", lsb2mem_addr, 32'h600);
        end
        rdy_in = 1'b1; mem_done = 1'b0;
        idle(2);
        check("held_after_rdy", {31'h0, lsb2mem_en}, 32'h1);
        serve(32'h12345678, 1'b1);
        idle(5);

        check("mem_q_empty", 32'(mem_q.size()), 32'h0);
        check("cdb_q_empty", 32'(cdb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
